// File: rtl/uart_defs.sv
// Shared UART definitions: SM state encodings (numbering shared with uart_rx), line level, frame width.
// UART_TX_PARITY_EN adds the PARITY state encoding and the even-parity helper.
package uart_defs;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY  = 3'd5
`endif
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam int   DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; full/empty flags are registered.
// A write while full is accepted only when a pop happens on the same edge.
module uart_tx_byte_fifo
  import uart_defs::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  wr_ok, pop_ok;

  assign pop_ok = pop_i && !empty_q;
  assign wr_ok  = wr_en_i && (!full_q || pop_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      // Non-empty is only announced once the written entry has settled for a cycle;
      // going empty is immediate so the SM never pops a stale slot.
      empty_q <= (count_d == '0) || (count_q == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO in front of an 8N1 shifter (idle-high line).
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module uart_tx_buffered
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT     = 868,
  parameter int CLK_COUNTER_BITS = 10,
  parameter int FIFO_DEPTH_LOG2  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Fifo_Empty
);

  localparam logic [CLK_COUNTER_BITS-1:0] CNT_LAST = CLK_COUNTER_BITS'(CLKS_PER_BIT - 1);
  localparam logic [CLK_COUNTER_BITS-1:0] CNT_ONE  = CLK_COUNTER_BITS'(1);

  tx_state_e             state_q;
  logic [CLK_COUNTER_BITS-1:0] cnt_q;
  logic [2:0]            bit_idx_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  serial_q, active_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  logic                  fifo_full, fifo_empty, pop_w, bit_end;
  logic [DATA_BITS-1:0]  fifo_head;

  assign pop_w   = (state_q == S_IDLE) && !fifo_empty;
  assign bit_end = (cnt_q == CNT_LAST);

  uart_tx_byte_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .wr_en_i  (i_Tx_DV),
    .wr_data_i(i_Tx_Byte),
    .pop_i    (pop_w),
    .rd_data_o(fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= LINE_IDLE;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          serial_q <= LINE_IDLE;
          active_q <= 1'b0;
          done_q   <= 1'b0;
          cnt_q    <= '0;
          if (pop_w) begin
            shift_q  <= fifo_head;
            serial_q <= 1'b0;
            active_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(fifo_head);
`endif
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            serial_q  <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial_q <= parity_q;
              state_q  <= S_PARITY;
`else
              serial_q <= LINE_IDLE;
              state_q  <= S_STOP;
`endif
            end else begin
              // Shift down so the next data bit is always at shift_q[1].
              shift_q   <= shift_q >> 1;
              serial_q  <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q    <= '0;
            serial_q <= LINE_IDLE;
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q    <= '0;
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_CLEANUP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_CLEANUP: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          serial_q <= LINE_IDLE;
          active_q <= 1'b0;
          done_q   <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Ready also covers the full-but-popping edge, where the FIFO takes the write.
  assign o_Tx_Ready   = !fifo_full || pop_w;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus pushes expected bytes, a line monitor decodes frames.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FCYC   = NBITS * CPB;
  localparam int PERIOD = FCYC + 2;

  logic       clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, ser, act, done, empty;

  uart_tx_buffered #(
    .CLKS_PER_BIT    (CPB),
    .CLK_COUNTER_BITS(3),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (din),
    .o_Tx_Ready  (ready),
    .o_Tx_Serial (ser),
    .o_Tx_Active (act),
    .o_Tx_Done   (done),
    .o_Fifo_Empty(empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  task automatic chk(input string name, input int actv, input int expv);
    tests++;
    if (actv !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actv, expv, cyc);
    end
  endtask

  always @(negedge clk) if (!rst && done) done_cnt++;

  // Line monitor: captures a whole frame sample-by-sample, checks every bit cell is flat.
  initial begin : mon
    int s;
    bit abort, bad;
    logic [NBITS-1:0] smp;
    logic [7:0] d, e;
    forever begin
      @(negedge clk);
      if (!rst && ser === 1'b0) begin
        s = cyc; abort = 0; bad = 0; smp = '0;
        for (int c = 0; c < FCYC; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) abort = 1;
          if (c % CPB == 0) smp[c/CPB] = ser;
          else if (ser !== smp[c/CPB]) bad = 1;
          if (act !== 1'b1) bad = 1;
        end
        if (!abort) begin
          @(negedge clk);
          starts.push_back(s);
          chk("frame_flat_active", int'(bad), 0);
          chk("stop_bit", int'(smp[NBITS-1]), 1);
          chk("done_after_stop", int'(done), 1);
          chk("active_after_stop", int'(act), 0);
          d = smp[8:1];
          chk("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_byte", int'(d), int'(e));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", int'(smp[9]), int'(^e));
`endif
          end
        end
      end
    end
  end

  // Offer one byte for one edge; ready seen before the edge decides acceptance.
  task automatic offer(input logic [7:0] b, output bit acc, output int k);
    dv = 1'b1; din = b;
    @(negedge clk);
    acc = ready;
    if (acc) exp_q.push_back(b);
    @(posedge clk); #1;
    k = cyc;
    dv = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || act || !empty) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", int'(n < budget), 1);
    repeat (6) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc, got;
    int k, nacc, s, n, bad;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_serial", int'(ser), 1);
    chk("rst_ready", int'(ready), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_active", int'(act), 0);
    @(posedge clk); #1 rst = 1'b0;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ser !== 1 || ready !== 1 || empty !== 1 || act !== 0 || done !== 0) bad++;
    end
    chk("idle_20", bad, 0);

    // Single byte 0xA5: latency, shape, one done pulse
    @(posedge clk); #1;
    starts.delete(); done_cnt = 0;
    offer(8'hA5, acc, k);
    chk("a5_accept", int'(acc), 1);
    drain(400);
    chk("a5_frames", starts.size(), 1);
    if (starts.size() > 0) chk("a5_latency", starts[0] - k, 2);
    chk("a5_done_once", done_cnt, 1);

    // Burst of five into a depth-4 FIFO; one pop frees a slot so all five fit
    @(posedge clk); #1;
    starts.delete(); nacc = 0;
    for (int i = 1; i <= 5; i++) begin
      offer(8'(i), acc, k);
      nacc += int'(acc);
    end
    chk("burst_accepts", nacc, 5);
    offer(8'h06, acc, k);
    chk("full_drop", int'(acc), 0);

    // Hold 0x55 while full; it lands on the edge where the SM pops
    dv = 1'b1; din = 8'h55; got = 0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (ready) begin got = 1; exp_q.push_back(8'h55); end
      @(posedge clk); #1;
      n++;
    end
    dv = 1'b0;
    chk("b55_accept", int'(got), 1);
    @(negedge clk);
    chk("b55_still_full", int'(ready), 0);
    chk("b55_not_empty", int'(empty), 0);
    drain(1000);
    chk("burst_frames", starts.size(), 6);
    for (int i = 1; i < starts.size(); i++) chk("b2b_period", starts[i] - starts[i-1], PERIOD);

    // Reset during bit 3 of 0xFF with two bytes queued
    @(posedge clk); #1;
    starts.delete();
    offer(8'hFF, acc, k);
    n = 0;
    while (ser !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("ff_started", int'(n < 50), 1);
    s = cyc;
    @(posedge clk); #1;
    offer(8'h11, acc, k);
    offer(8'h22, acc, k);
    while (cyc < s + 17) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    chk("rstmid_serial", int'(ser), 1);
    chk("rstmid_active", int'(act), 0);
    chk("rstmid_empty", int'(empty), 1);
    chk("rstmid_ready", int'(ready), 1);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser !== 1'b1 || act !== 1'b0) bad++;
    end
    chk("rstmid_quiet", bad, 0);
    chk("rstmid_no_frames", starts.size(), 0);

`ifdef UART_TX_PARITY_EN
    @(posedge clk); #1;
    starts.delete();
    offer(8'h07, acc, k);
    offer(8'h03, acc, k);
    drain(600);
    chk("par_frames", starts.size(), 2);
    if (starts.size() == 2) chk("par_period", starts[1] - starts[0], PERIOD);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
